// File: rtl/fmc_adc_ddr_wr_pkg.sv
// Shared types and helpers for the FMC-ADC DDR Wishbone writer.
package fmc_adc_ddr_wr_pkg;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FLUSH, DONE} t_ddr_wr_state;

  localparam int         c_SMP_WIDTH = 64;
  localparam logic [7:0] c_SEL_ALL   = 8'hFF;

  // Word address modulo DDR size; mem_words need not be a power of two.
  function automatic logic [31:0] f_addr_wrap(input logic [32:0] addr, input logic [32:0] mem_words);
    return 32'(addr % mem_words);
  endfunction

endpackage

// File: rtl/fmc_adc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_data shows the head while !empty.
module fmc_adc_sync_fifo #(
  parameter int g_depth = 16,
  parameter int g_width = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [g_width-1:0] wr_data,
  input  logic               rd_en,
  output logic [g_width-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int c_AW = $clog2(g_depth);

  logic [g_width-1:0] mem [g_depth];
  logic [c_AW-1:0]    wr_ptr, rd_ptr;
  logic [c_AW:0]      count;
  logic               wr, rd;

  assign full    = (count == (c_AW+1)'(g_depth));
  assign empty   = (count == '0);
  assign wr      = wr_en && !full;
  assign rd      = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !rd)      count <= count + 1'b1;
      else if (rd && !wr) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fmc_adc_ddr_wb_writer.sv
// Streams 64-bit ADC samples into DDR over pipelined Wishbone with wrapping
// word addresses; reports completion once all beats are acked and DDR drained.
module fmc_adc_ddr_wb_writer
  import fmc_adc_ddr_wr_pkg::*;
#(
  parameter int          g_fifo_depth      = 16,
  parameter int          g_max_outstanding = 15,
  parameter int unsigned g_mem_words       = 2**25
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rst_i,
  input  logic                   acq_start_i,
  input  logic                   acq_end_i,
  input  logic [31:0]            start_addr_i,
  input  logic [c_SMP_WIDTH-1:0] smp_data_i,
  input  logic                   smp_valid_i,
  output logic [31:0]            wb_ddr_adr_o,
  output logic [c_SMP_WIDTH-1:0] wb_ddr_dat_o,
  output logic [7:0]             wb_ddr_sel_o,
  output logic                   wb_ddr_cyc_o,
  output logic                   wb_ddr_stb_o,
  output logic                   wb_ddr_we_o,
  input  logic                   wb_ddr_ack_i,
  input  logic                   wb_ddr_stall_i,
  input  logic                   ddr_wr_fifo_empty_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o,
  output logic [31:0]            wr_cnt_o
);

  localparam int          c_OS_W  = $clog2(g_max_outstanding + 1);
  localparam logic [32:0] c_MEM_W = 33'(g_mem_words);

  t_ddr_wr_state          state_q, state_d;
  logic                   arm, push_en;
  logic                   fifo_full, fifo_empty, push, load, accept, ack_eff;
  logic [c_SMP_WIDTH-1:0] fifo_dout;
  logic [c_OS_W-1:0]      os_q, os_nxt;
  logic [31:0]            addr_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acq_start_i) state_d = RUN;
      RUN:     if (acq_end_i) state_d = DRAIN;
      // The output register counts as pending until its beat is accepted.
      DRAIN:   if (fifo_empty && !wb_ddr_stb_o && os_q == '0) state_d = FLUSH;
      FLUSH:   if (ddr_wr_fifo_empty_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == DONE);
    push_en = (state_q == RUN);
    arm     = (state_q == IDLE) && acq_start_i;
  end

  assign push    = push_en && smp_valid_i && !fifo_full;
  assign accept  = wb_ddr_stb_o && !wb_ddr_stall_i;
  assign ack_eff = wb_ddr_ack_i && (os_q != '0);

  always_comb begin
    os_nxt = os_q;
    if (accept && !ack_eff)      os_nxt = os_q + 1'b1;
    else if (!accept && ack_eff) os_nxt = os_q - 1'b1;
  end

  // Refill the strobe register whenever it is free or being accepted, so beats
  // stream back-to-back; gate on the post-edge outstanding count.
  assign load = !fifo_empty && (os_nxt < c_OS_W'(g_max_outstanding)) && (!wb_ddr_stb_o || accept);

  fmc_adc_sync_fifo #(
    .g_depth (g_fifo_depth),
    .g_width (c_SMP_WIDTH)
  ) u_fifo (
    .clk     (sys_clk_i),
    .rst     (sys_rst_i),
    .wr_en   (push),
    .wr_data (smp_data_i),
    .rd_en   (load),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      os_q         <= '0;
      wr_cnt_o     <= '0;
      overflow_o   <= 1'b0;
      addr_q       <= '0;
      wb_ddr_stb_o <= 1'b0;
      wb_ddr_adr_o <= '0;
      wb_ddr_dat_o <= '0;
    end else begin
      os_q <= os_nxt;
      if (ack_eff) wr_cnt_o <= wr_cnt_o + 32'd1;
      if (push_en && smp_valid_i && fifo_full) overflow_o <= 1'b1;
      if (arm) begin
        wr_cnt_o   <= '0;
        overflow_o <= 1'b0;
        addr_q     <= f_addr_wrap({1'b0, start_addr_i}, c_MEM_W);
      end
      if (load) begin
        wb_ddr_stb_o <= 1'b1;
        wb_ddr_adr_o <= addr_q;
        wb_ddr_dat_o <= fifo_dout;
        addr_q       <= f_addr_wrap({1'b0, addr_q} + 33'd1, c_MEM_W);
      end else if (accept) begin
        wb_ddr_stb_o <= 1'b0;
      end
    end
  end

  assign wb_ddr_cyc_o = wb_ddr_stb_o || (os_q != '0);
  assign wb_ddr_sel_o = c_SEL_ALL;
  assign wb_ddr_we_o  = 1'b1;

endmodule

// File: tb/tb_fmc_adc_ddr_wb_writer.sv
// Bench: two writers (default DDR size and a 64-word DDR) share one stimulus and
// a behavioural Wishbone slave; beats are scored against a queue/address model.
module tb_fmc_adc_ddr_wb_writer;

  typedef longint unsigned u64_t;
  localparam u64_t MEM_A = 64'd33554432;
  localparam u64_t MEM_B = 64'd64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, acq_start = 1'b0, acq_end = 1'b0, smp_valid = 1'b0;
  logic        ack = 1'b0, stall = 1'b0, ddr_empty = 1'b1;
  logic [31:0] start_addr = '0;
  logic [63:0] smp_data = '0;

  logic [31:0] adr_a, adr_b, wrcnt_a, wrcnt_b;
  logic [63:0] dat_a, dat_b;
  logic [7:0]  sel_a, sel_b;
  logic        cyc_a, stb_a, we_a, busy_a, done_a, ovf_a;
  logic        cyc_b, stb_b, we_b, busy_b, done_b, ovf_b;

  fmc_adc_ddr_wb_writer u_dut_a (
    .sys_clk_i(clk), .sys_rst_i(rst), .acq_start_i(acq_start), .acq_end_i(acq_end),
    .start_addr_i(start_addr), .smp_data_i(smp_data), .smp_valid_i(smp_valid),
    .wb_ddr_adr_o(adr_a), .wb_ddr_dat_o(dat_a), .wb_ddr_sel_o(sel_a), .wb_ddr_cyc_o(cyc_a),
    .wb_ddr_stb_o(stb_a), .wb_ddr_we_o(we_a), .wb_ddr_ack_i(ack), .wb_ddr_stall_i(stall),
    .ddr_wr_fifo_empty_i(ddr_empty), .busy_o(busy_a), .done_o(done_a),
    .overflow_o(ovf_a), .wr_cnt_o(wrcnt_a));

  fmc_adc_ddr_wb_writer #(.g_mem_words(64)) u_dut_b (
    .sys_clk_i(clk), .sys_rst_i(rst), .acq_start_i(acq_start), .acq_end_i(acq_end),
    .start_addr_i(start_addr), .smp_data_i(smp_data), .smp_valid_i(smp_valid),
    .wb_ddr_adr_o(adr_b), .wb_ddr_dat_o(dat_b), .wb_ddr_sel_o(sel_b), .wb_ddr_cyc_o(cyc_b),
    .wb_ddr_stb_o(stb_b), .wb_ddr_we_o(we_b), .wb_ddr_ack_i(ack), .wb_ddr_stall_i(stall),
    .ddr_wr_fifo_empty_i(ddr_empty), .busy_o(busy_b), .done_o(done_b),
    .overflow_o(ovf_b), .wr_cnt_o(wrcnt_b));

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [63:0] exp_q[$];
  int          ack_due[$];
  int          cyc_n = 0, os_model = 0, acks_model = 0, beat_k = 0, done_cnt = 0, last_due = 0;
  int          dly_lo = 1, dly_hi = 1, stall_mode = 0;
  bit          skip_mode = 1'b0, prev_hold = 1'b0, prev_done = 1'b0;
  logic [31:0] start_model = '0, hold_adr_a = '0, hold_adr_b = '0;
  logic [63:0] hold_dat = '0;

  function automatic logic [31:0] exp_adr(input u64_t mem);
    return 32'((u64_t'(start_model) % mem + u64_t'(beat_k)) % mem);
  endfunction

  function automatic logic [63:0] rnd_smp(input int i);
    return {32'($urandom), 16'hC0DE, 16'(i)};
  endfunction

  task automatic check_beat();
    int sk = 0;
    if (skip_mode)
      while (exp_q.size() > 0 && exp_q[0] !== dat_a) begin
        void'(exp_q.pop_front());
        sk++;
      end
    if (skip_mode && beat_k < 16) chk("first16_kept", 64'(sk), 64'd0);
    chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      chk("wb_dat", dat_a, e);
      chk("wb_dat_b", dat_b, e);
    end
    chk("wb_adr", 64'(adr_a), 64'(exp_adr(MEM_A)));
    chk("wb_adr_wrap64", 64'(adr_b), 64'(exp_adr(MEM_B)));
    chk("wb_sel", 64'({sel_a, sel_b}), 64'hFFFF);
    chk("wb_we", 64'({we_a, we_b}), 64'd3);
    beat_k++;
  endtask

  // Wishbone slave + monitor: acts 1 time unit after each falling edge, so the
  // stall/ack it drives and the outputs it sees both hold through the next rise.
  always @(negedge clk) begin
    int due;
    #1;
    cyc_n++;
    chk("cyc_a", 64'(cyc_a), 64'(stb_a || os_model != 0));
    chk("cyc_b", 64'(cyc_b), 64'(stb_b || os_model != 0));
    chk("wr_cnt", 64'(wrcnt_a), 64'(acks_model));
    if (prev_hold) begin
      chk("hold_stb", 64'(stb_a), 64'd1);
      chk("hold_adr", 64'(adr_a), 64'(hold_adr_a));
      chk("hold_adr_b", 64'(adr_b), 64'(hold_adr_b));
      chk("hold_dat", dat_a, hold_dat);
    end
    chk("done_single", 64'(done_a && prev_done), 64'd0);
    if (done_a) done_cnt++;
    prev_done = done_a;
    if (rst) begin
      ack_due.delete();
      os_model = 0; acks_model = 0; last_due = 0;
      ack = 1'b0; stall = 1'b0; prev_hold = 1'b0;
    end else begin
      case (stall_mode)
        0:       stall = 1'b0;
        1:       stall = (cyc_n % 4) != 3;
        2:       stall = 1'b1;
        default: stall = ($urandom_range(0, 9) < 3);
      endcase
      ack = 1'b0;
      if (ack_due.size() > 0 && ack_due[0] == cyc_n) begin
        void'(ack_due.pop_front());
        ack = 1'b1; os_model--; acks_model++;
      end
      if (stb_a && !stall) begin
        check_beat();
        os_model++;
        due = cyc_n + int'($urandom_range(dly_lo, dly_hi));
        if (due <= last_due) due = last_due + 1;
        ack_due.push_back(due);
        last_due = due;
      end
      prev_hold = stb_a && stall;
      hold_adr_a = adr_a; hold_adr_b = adr_b; hold_dat = dat_a;
      chk("os_max", 64'(os_model <= 15), 64'd1);
    end
  end

  task automatic start_acq(input logic [31:0] a, input bit junk);
    acq_start = 1'b1; start_addr = a;
    start_model = a; beat_k = 0; exp_q.delete();
    if (junk) begin smp_valid = 1'b1; smp_data = 64'hDEAD_BEEF_0BAD_F00D; end
    @(negedge clk);
    acq_start = 1'b0; smp_valid = 1'b0; acks_model = 0;
    chk("start_busy", 64'(busy_a), 64'd1);
    chk("start_ovf_clr", 64'(ovf_a), 64'd0);
  endtask

  task automatic send(input logic [63:0] d);
    smp_valid = 1'b1; smp_data = d; exp_q.push_back(d);
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  task automatic end_acq(input bit with_smp, input logic [63:0] d);
    acq_end = 1'b1;
    if (with_smp) begin smp_valid = 1'b1; smp_data = d; exp_q.push_back(d); end
    @(negedge clk);
    acq_end = 1'b0; smp_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c0 = done_cnt;
    for (int i = 0; i < 3000 && done_cnt == c0; i++) @(negedge clk);
    chk({tag, "_done"}, 64'(done_cnt - c0), 64'd1);
    chk({tag, "_idle"}, 64'(busy_a), 64'd0);
    chk({tag, "_wr_cnt"}, 64'(wrcnt_a), 64'(beat_k));
    if (!skip_mode) chk({tag, "_all_written"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cyc", 64'({cyc_a, cyc_b}), 64'd0);
    chk("rst_stb", 64'({stb_a, stb_b}), 64'd0);
    chk("rst_adr", 64'(adr_a), 64'd0);
    chk("rst_dat", dat_a, 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    chk("rst_wr_cnt", 64'(wrcnt_a), 64'd0);
    rst = 1'b0;

    // 1: eight beats from 0x100, no stall, checks two-cycle push-to-strobe latency
    start_acq(32'h100, 1'b0);
    smp_valid = 1'b1; smp_data = 64'd1; exp_q.push_back(64'd1);
    @(negedge clk);
    chk("lat_n1_stb", 64'(stb_a), 64'd0);
    smp_data = 64'd2; exp_q.push_back(64'd2);
    @(negedge clk);
    chk("lat_n2_stb", 64'(stb_a), 64'd1);
    chk("lat_n2_dat", dat_a, 64'd1);
    for (int i = 3; i <= 8; i++) send(64'(i));
    end_acq(1'b0, '0);
    wait_done("t1");
    chk("t1_wr_cnt8", 64'(wrcnt_a), 64'd8);
    chk("t1_ovf", 64'(ovf_a), 64'd0);

    // 2: stall 3-on/1-off, ack after 5, 32 samples one per 4 cycles; stray start ignored
    stall_mode = 1; dly_lo = 5; dly_hi = 5;
    start_acq($urandom, 1'b0);
    for (int i = 0; i < 32; i++) begin
      send(rnd_smp(i));
      if (i == 10) begin acq_start = 1'b1; start_addr = $urandom; end
      @(negedge clk);
      acq_start = 1'b0;
      repeat (2) @(negedge clk);
    end
    end_acq(1'b0, '0);
    wait_done("t2");
    chk("t2_wr_cnt32", 64'(wrcnt_a), 64'd32);

    // 3: wrap at 64 words from 0x3E; a sample with the start pulse is discarded
    stall_mode = 0; dly_lo = 1; dly_hi = 3;
    start_acq(32'h3E, 1'b1);
    for (int i = 0; i < 4; i++) send(rnd_smp(i));
    end_acq(1'b0, '0);
    wait_done("t3");
    chk("t3_ovf", 64'(ovf_a), 64'd0);

    // 4: stall held 40 cycles under continuous valid, long ack delay
    stall_mode = 2; dly_lo = 20; dly_hi = 20; skip_mode = 1'b1;
    start_acq($urandom, 1'b0);
    for (int i = 0; i < 40; i++) send(rnd_smp(i));
    stall_mode = 0;
    chk("t4_ovf_set", 64'(ovf_a), 64'd1);
    end_acq(1'b0, '0);
    wait_done("t4");
    chk("t4_ovf_sticky", 64'(ovf_a), 64'd1);
    chk("t4_beats_ge16", 64'(beat_k >= 16), 64'd1);
    skip_mode = 1'b0;

    // 7: random stall, random ack delay, random gaps and end-with-sample
    stall_mode = 3; dly_lo = 1; dly_hi = 8;
    start_acq($urandom, 1'b0);
    for (int i = 0; i < 40; i++) begin
      send(rnd_smp(i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    end_acq(1'($urandom), rnd_smp(99));
    wait_done("t7");

    // 5: reset with five beats outstanding, then clean restart at 0x200
    stall_mode = 0; dly_lo = 12; dly_hi = 12;
    start_acq($urandom, 1'b0);
    for (int i = 0; i < 8; i++) send(rnd_smp(i));
    for (int i = 0; i < 60 && os_model != 5; i++) @(negedge clk);
    chk("t5_os_pre", 64'(os_model), 64'd5);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_cyc", 64'(cyc_a), 64'd0);
    chk("t5_stb", 64'(stb_a), 64'd0);
    chk("t5_busy", 64'(busy_a), 64'd0);
    chk("t5_wr_cnt", 64'(wrcnt_a), 64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_quiet_cyc", 64'(cyc_a), 64'd0);
    dly_lo = 1; dly_hi = 4;
    start_acq(32'h200, 1'b0);
    for (int i = 0; i < 6; i++) send(rnd_smp(i));
    end_acq(1'b0, '0);
    wait_done("t5");

    // 6: end coincident with a sample; DDR write FIFO not empty for 10 cycles
    start_acq($urandom, 1'b0);
    for (int i = 0; i < 5; i++) send(rnd_smp(i));
    ddr_empty = 1'b0;
    end_acq(1'b1, rnd_smp(5));
    for (int i = 0; i < 500 && (cyc_a || exp_q.size() != 0); i++) @(negedge clk);
    chk("t6_last_written", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_hold_done", 64'(done_a), 64'd0);
      chk("t6_hold_busy", 64'(busy_a), 64'd1);
    end
    ddr_empty = 1'b1;
    @(negedge clk);
    chk("t6_done", 64'(done_a), 64'd1);
    @(negedge clk);
    chk("t6_done_end", 64'(done_a), 64'd0);
    chk("t6_idle", 64'(busy_a), 64'd0);
    chk("t6_wr_cnt", 64'(wrcnt_a), 64'd6);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fmc_adc_ddr_wb_writer.md
Name: fmc_adc_ddr_wb_writer

Overview:
- Downstream stage of the FMC-ADC acquisition core. Consumes the 64-bit multi-channel sample stream (4 × 16-bit channels) produced after trigger/decimation.
- Writes the stream into DDR through the pipelined Wishbone master interface (wb_ddr_*), with auto-incrementing, wrapping word addresses.
- Signals end of acquisition only after every beat has been acknowledged and the DDR controller write FIFO has drained.
- Clocked on the DDR Wishbone clock domain; the sample stream arrives already synchronised to it.

Parameters:
- g_fifo_depth, 16: sample FIFO depth in 64-bit words; power of two, minimum 4.
- g_max_outstanding, 15: maximum number of accepted but unacknowledged Wishbone beats.
- g_mem_words, 2**25: DDR size in 64-bit words. Addresses wrap to 0 after g_mem_words-1.

Ports:
- sys_clk_i  in  1  clock (shared with the Wishbone DDR bus)
- sys_rst_i  in  1  synchronous reset, active-high
- acq_start_i  in  1  one-cycle pulse: arm the writer and load start address
- acq_end_i  in  1  one-cycle pulse: no further samples follow
- start_addr_i  in  32  first DDR word address, sampled on acq_start_i
- smp_data_i  in  64  sample word {ch4,ch3,ch2,ch1}
- smp_valid_i  in  1  sample qualifier; no back-pressure exists (continuous ADC stream)
- wb_ddr_adr_o  out  32  word address
- wb_ddr_dat_o  out  64  write data
- wb_ddr_sel_o  out  8  byte select, constant 0xFF
- wb_ddr_cyc_o  out  1  Wishbone cycle
- wb_ddr_stb_o  out  1  Wishbone strobe
- wb_ddr_we_o  out  1  write enable, constant 1
- wb_ddr_ack_i  in  1  Wishbone acknowledge
- wb_ddr_stall_i  in  1  Wishbone pipelined stall
- ddr_wr_fifo_empty_i  in  1  DDR controller write FIFO empty
- busy_o  out  1  writer not in IDLE
- done_o  out  1  one-cycle pulse: acquisition fully committed to DDR
- overflow_o  out  1  sticky: at least one sample dropped because the FIFO was full
- wr_cnt_o  out  32  number of acknowledged beats in the current acquisition

Behaviour:
- Reset (sys_rst_i=1 at a clock edge):
  - state returns to IDLE; FIFO is flushed; outstanding and wr_cnt are cleared.
  - outputs: cyc=0, stb=0, adr=0, dat=0, busy=0, done=0, overflow=0.
  - Mid-transfer reset drops cyc the same edge; pending acks are discarded.
- States: IDLE → RUN → DRAIN → FLUSH → DONE → IDLE.
  - IDLE: on acq_start_i, load addr←start_addr_i mod g_mem_words, clear wr_cnt and overflow, go to RUN. A sample valid in the same cycle is discarded and not counted as overflow.
  - RUN: on smp_valid_i with FIFO not full, push the sample. With FIFO full, drop the sample and set overflow_o. On acq_end_i, go to DRAIN; a sample valid in the same cycle is still pushed.
  - DRAIN: no pushes. When FIFO is empty and outstanding=0, go to FLUSH.
  - FLUSH: when ddr_wr_fifo_empty_i=1, go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- acq_start_i and acq_end_i are ignored in any state other than the one that consumes them.
- Wishbone master, pipelined:
  - stb_o is registered. It asserts when the FIFO is non-empty and outstanding < g_max_outstanding.
  - A beat is accepted when stb & !stall. On acceptance: pop the FIFO, addr←(addr+1) wraps at g_mem_words, outstanding+1.
  - While stalled, adr/dat/stb hold stable.
  - Back-to-back beats are allowed: one beat per cycle at stall=0.
  - cyc_o = stb_o OR outstanding≠0.
  - ack_i: outstanding-1 and wr_cnt+1. Accept and ack in the same cycle leave outstanding unchanged.
  - ack_i while outstanding=0 is ignored.
- Latency: a sample pushed at cycle N appears on stb/dat at N+2 when the bus is idle and unstalled (FIFO read plus output register).
- busy_o = state≠IDLE.

Decomposition:
- Package fmc_adc_ddr_wr_pkg:
  - state enum t_ddr_wr_state (IDLE, RUN, DRAIN, FLUSH, DONE)
  - c_SMP_WIDTH=64, c_SEL_ALL=8'hFF
  - function f_addr_wrap
- Sub-module fmc_adc_sync_fifo: generic single-clock first-word-fall-through FIFO with full/empty flags and synchronous active-high reset.

Test Plan:
1. Start at 0x100, push 8 samples 0x0001..0x0008 with no stall, then acq_end_i.
   - Expect 8 beats at adr 0x100..0x107 with matching data, wr_cnt_o=8.
   - done_o pulses once after ddr_wr_fifo_empty_i=1; overflow_o=0.
2. Alternate stall 3 cycles on / 1 off; ack delayed 5 cycles; 32 samples at 1 per 4 cycles.
   - All 32 written in order; adr/dat stable during stall; outstanding never exceeds 15.
3. g_mem_words=64, start 0x3E, 4 samples.
   - Addresses 0x3E, 0x3F, 0x00, 0x01.
4. Stall held high for 40 cycles, continuous valid.
   - FIFO fills after 16 pushes; overflow_o=1 and stays 1.
   - Next acq_start_i clears overflow_o; no beat is corrupted.
5. Reset asserted with 5 beats outstanding.
   - Next cycle cyc=stb=0, busy=0; a later start at 0x200 writes cleanly from 0x200.
6. acq_end_i coincident with a valid sample, with ddr_wr_fifo_empty_i held 0 for 10 cycles.
   - Last sample is written; state holds in FLUSH; done_o pulses on the cycle after empty rises.
